pipe_skid_stage: RTL and testbench
==================================

# pipe_skid_stage

Parametrised pipeline-stage register that replaces the plain stall/clear stage register. It adds a valid/ready handshake, a two-entry skid buffer so that `in_ready` is a registered signal, and flush handling that drops buffered entries. It also provides saturating performance counters for back-pressure and flushed entries. It sits between any two MIPS pipeline stages, for example IF/ID or ID/EX, with the payload packed into `in_data`.

## Interface
Parameters:
- `WIDTH`, 32, payload width in bits
- `CNT_W`, 16, width of each performance counter

Ports:
- `clk`  input  1  single clock; all state updates on its rising edge
- `reset`  input  1  synchronous, active-high; highest priority
- `flush`  input  1  discards all held entries this cycle; second priority after `reset`
- `in_valid`  input  1  upstream presents `in_data`
- `in_ready`  output  1  stage can accept; registered state, gated low by `flush`
- `in_data`  input  WIDTH  upstream payload
- `out_valid`  output  1  `out_data` is valid; gated low by `flush`
- `out_ready`  input  1  downstream accepts
- `out_data`  output  WIDTH  payload of the main entry, driven directly from a register
- `stall_cnt`  output  CNT_W  cycles with `out_valid & !out_ready`; saturating
- `drop_cnt`  output  CNT_W  entries discarded by flush; saturating

## Operation
- Storage:
  - main entry register `main_q` drives `out_data`.
  - skid register `skid_q` holds an overflow beat.
- State is one of:
  - EMPTY: nothing held
  - ONE: `main_q` valid
  - TWO: `main_q` and `skid_q` valid
- Output definitions:
  - `in_ready = (state != TWO) & !flush`
  - `out_valid = (state != EMPTY) & !flush`
- Handshake terms:
  - accept: `in_valid & in_ready`
  - send: `out_valid & out_ready`
- Transitions when neither `reset` nor `flush` is high:
  - EMPTY, accept: -> ONE, `main_q <= in_data`
  - ONE, accept & send: stay ONE, `main_q <= in_data`
  - ONE, accept & !send: -> TWO, `skid_q <= in_data`
  - ONE, !accept & send: -> EMPTY
  - TWO, send: -> ONE, `main_q <= skid_q`. No accept is possible in TWO.
  - All other cases: hold state and data.
- `flush`:
  - Next state is EMPTY; `main_q` and `skid_q` clear to 0.
  - No transfer occurs in either direction on a flush cycle, so `in_data` is dropped.
  - `drop_cnt` adds 0, 1 or 2 for EMPTY, ONE or TWO respectively, saturating.
- `stall_cnt`:
  - Increments by 1 on each non-flush cycle where the state is not EMPTY and `out_ready` is 0.
  - Saturates at 2^CNT_W-1.
- Neither counter is cleared by `flush`; only `reset` clears them.
- Data ordering is strictly FIFO and no beat is duplicated.

## Timing
- Reset values (all synchronous): state EMPTY, `main_q` 0, `skid_q` 0, `stall_cnt` 0, `drop_cnt` 0.
- Resulting outputs after reset: `out_valid` 0, `out_data` 0, `in_ready` 1.
- `reset` asserted mid-operation, including together with `flush`, behaves exactly as reset; flush counting is suppressed.
- Latency: a beat accepted at edge N is visible on `out_valid`/`out_data` after edge N, in cycle N+1.
- Throughput: one beat per cycle when `out_ready` is held at 1.
- `in_ready` falls one cycle after the first back-pressured cycle. The beat accepted in that cycle lands in `skid_q`.
- The only combinational input-to-output paths are `flush` -> `in_ready` and `flush` -> `out_valid`. `in_ready` has no dependency on `out_ready` or `in_valid`.
- Counter saturation: at the maximum value an increment holds the value. For `drop_cnt`, adding 2 at max-1 yields max.

## Structure
- Shared package/header `pipe_pkg`:
  - state encodings EMPTY=2'd0, ONE=2'd1, TWO=2'd2; the value 2'd3 is unreachable and decodes to EMPTY.
  - default `CNT_W`.
- Sub-module `sat_counter #(W)`:
  - ports `clk`, `reset`, `inc[1:0]`, `count[W-1:0]`.
  - instantiated twice, for `stall_cnt` and `drop_cnt`.
- The top level holds the state machine and data registers only.

## Test plan
- Reset: assert `reset` for 2 cycles with `in_valid`=1 and `in_data`=0xDEADBEEF. Required: `out_valid`=0, `out_data`=0, `in_ready`=1 and both counters 0 throughout; state EMPTY after release.
- Streaming: send 0x1..0x8 on consecutive cycles with `out_ready`=1. Required: outputs appear 0x1..0x8 on consecutive cycles, each one cycle after its accept; `stall_cnt`=0.
- Skid: send 0xA, 0xB, 0xC back-to-back while `out_ready`=0 from the second cycle onward.
  - Required: 0xA is held on the output and 0xB is captured in `skid_q`.
  - `in_ready`=0 while two entries are held, so 0xC is not accepted.
  - Raise `out_ready`: 0xA then 0xB are emitted; 0xC is accepted once `in_ready`=1 again.
  - `stall_cnt` equals the number of blocked cycles.
- Flush in TWO: hold two entries, then pulse `flush` with `in_valid`=1 and data 0x55. Required: `in_ready`=0 and `out_valid`=0 that cycle, then state EMPTY, `out_data`=0, `drop_cnt`=2, and 0x55 never appears.
- Saturation: run with `CNT_W`=2, back-pressure for 6 cycles, then flush in TWO twice. Required: `stall_cnt`=3 and `drop_cnt`=3, with neither wrapping.
- Reset with flush: assert `reset` and `flush` together in state ONE. Required: `drop_cnt` stays 0 and all outputs are at their reset values.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the skid-buffered pipeline stage.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_e;

    localparam int CNT_W_DEFAULT = 16;

endpackage

// File: rtl/sat_counter.sv
// Saturating performance counter; adds 0..3 per cycle and sticks at all-ones.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [1:0]   inc,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] MAX = '1;

    // Two extra bits so the sum cannot wrap before the saturation compare.
    logic [W+1:0] sum;
    assign sum = {2'b00, count} + {{W{1'b0}}, inc};

    always_ff @(posedge clk) begin
        if (reset)
            count <= '0;
        else if (sum > {2'b00, MAX})
            count <= MAX;
        else
            count <= sum[W-1:0];
    end

endmodule

// File: rtl/pipe_skid_stage.sv
// Pipeline stage register with valid/ready handshake, two-entry skid buffer and flush.
module pipe_skid_stage
    import pipe_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] drop_cnt
);

    state_e           state_q;
    state_e           st;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;
    logic             accept;
    logic             send;
    logic [1:0]       stall_inc;
    logic [1:0]       drop_inc;

    // The unused encoding behaves as EMPTY.
    always_comb begin
        case (state_q)
            ONE:     st = ONE;
            TWO:     st = TWO;
            default: st = EMPTY;
        endcase
    end

    assign in_ready  = (st != TWO) & ~flush;
    assign out_valid = (st != EMPTY) & ~flush;
    assign out_data  = main_q;
    assign accept    = in_valid & in_ready;
    assign send      = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else if (flush) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            case (st)
                EMPTY: if (accept) begin
                    state_q <= ONE;
                    main_q  <= in_data;
                end
                ONE: begin
                    if (accept && send) begin
                        main_q <= in_data;
                    end else if (accept) begin
                        state_q <= TWO;
                        skid_q  <= in_data;
                    end else if (send) begin
                        state_q <= EMPTY;
                    end
                end
                TWO: if (send) begin
                    state_q <= ONE;
                    main_q  <= skid_q;
                end
                default: state_q <= EMPTY;
            endcase
        end
    end

    always_comb begin
        stall_inc = {1'b0, ~flush & (st != EMPTY) & ~out_ready};
        drop_inc  = 2'd0;
        if (flush) begin
            case (st)
                ONE:     drop_inc = 2'd1;
                TWO:     drop_inc = 2'd2;
                default: drop_inc = 2'd0;
            endcase
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (stall_inc),
        .count (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_drop_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (drop_inc),
        .count (drop_cnt)
    );

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Randomised and directed bench for pipe_skid_stage with a queue-based reference model.
module tb_pipe_skid_stage;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, out_ready;
    logic [31:0] in_data;

    logic        in_ready, out_valid, s_in_ready, s_out_valid;
    logic [31:0] out_data, s_out_data;
    logic [15:0] stall_cnt, drop_cnt;
    logic [1:0]  s_stall_cnt, s_drop_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pipe_skid_stage #(.WIDTH(32), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .stall_cnt(stall_cnt), .drop_cnt(drop_cnt)
    );

    pipe_skid_stage #(.WIDTH(32), .CNT_W(2)) dut_s (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data),
        .stall_cnt(s_stall_cnt), .drop_cnt(s_drop_cnt)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic longint sat(input longint v, input int w);
        longint mx = (64'd1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    // Reference model: the held beats as a FIFO, plus plain integer event counts.
    logic [31:0] q[$];
    logic [31:0] last_main;
    longint      stall_m, drop_m;
    bit          model_ok = 0;

    always @(negedge clk) begin
        if (model_ok) begin
            logic [31:0] exp_data;
            exp_data = (q.size() > 0) ? q[0] : last_main;
            chk("out_valid",   {63'd0, out_valid},   {63'd0, (q.size() > 0) && !flush});
            chk("in_ready",    {63'd0, in_ready},    {63'd0, (q.size() < 2) && !flush});
            chk("out_data",    {32'd0, out_data},    {32'd0, exp_data});
            chk("s_out_valid", {63'd0, s_out_valid}, {63'd0, (q.size() > 0) && !flush});
            chk("s_in_ready",  {63'd0, s_in_ready},  {63'd0, (q.size() < 2) && !flush});
            chk("s_out_data",  {32'd0, s_out_data},  {32'd0, exp_data});
            chk("stall_cnt",   {48'd0, stall_cnt},   sat(stall_m, 16));
            chk("drop_cnt",    {48'd0, drop_cnt},    sat(drop_m, 16));
            chk("s_stall_cnt", {62'd0, s_stall_cnt}, sat(stall_m, 2));
            chk("s_drop_cnt",  {62'd0, s_drop_cnt},  sat(drop_m, 2));
        end
        // Advance the model to reflect the coming rising edge.
        if (reset) begin
            q.delete();
            last_main = '0;
            stall_m   = 0;
            drop_m    = 0;
            model_ok  = 1;
        end else if (model_ok) begin
            if (flush) begin
                drop_m += q.size();
                q.delete();
                last_main = '0;
            end else begin
                bit rdy;
                rdy = q.size() < 2;
                if (q.size() > 0 && !out_ready) stall_m++;
                if (q.size() > 0 && out_ready) last_main = q.pop_front();
                if (in_valid && rdy) q.push_back(in_data);
            end
        end
    end

    task automatic cyc(input logic r, input logic f, input logic v,
                       input logic [31:0] d, input logic o);
        reset = r; flush = f; in_valid = v; in_data = d; out_ready = o;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1; flush = 0; in_valid = 1; in_data = 32'hDEADBEEF; out_ready = 0;
        @(posedge clk); #1;

        // Reset with in_valid asserted
        cyc(1, 0, 1, 32'hDEADBEEF, 0);
        cyc(1, 0, 1, 32'hDEADBEEF, 0);
        cyc(0, 0, 0, 32'h0, 1);

        // Streaming at full rate
        for (int i = 1; i <= 8; i++) cyc(0, 0, 1, i, 1);
        cyc(0, 0, 0, 0, 1);
        chk("stream_stall", {48'd0, stall_cnt}, 64'd0);

        // Skid: B lands in the skid register, C waits for space
        cyc(0, 0, 1, 32'hA, 1);
        cyc(0, 0, 1, 32'hB, 0);
        chk("skid_head", {32'd0, out_data}, 64'hA);
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 32'hC, 0);
        chk("skid_full", {63'd0, in_ready}, 64'd0);
        cyc(0, 0, 1, 32'hC, 1);
        cyc(0, 0, 1, 32'hC, 1);
        cyc(0, 0, 0, 32'h0, 1);
        cyc(0, 0, 0, 32'h0, 1);
        chk("skid_stall", {48'd0, stall_cnt}, 64'd4);

        // Flush while holding two entries, with 0x55 offered
        cyc(0, 0, 1, 32'h21, 0);
        cyc(0, 0, 1, 32'h22, 0);
        cyc(0, 1, 1, 32'h55, 1);
        chk("flush_drop", {48'd0, drop_cnt}, 64'd2);
        chk("flush_data", {32'd0, out_data}, 64'd0);
        cyc(0, 0, 0, 32'h0, 1);
        cyc(0, 0, 0, 32'h0, 1);

        // Saturation of the narrow counters
        cyc(1, 0, 0, 32'h0, 0);
        cyc(0, 0, 1, 32'h11, 0);
        cyc(0, 0, 1, 32'h12, 0);
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 32'h0, 0);
        cyc(0, 1, 0, 32'h0, 0);
        cyc(0, 0, 1, 32'h13, 0);
        cyc(0, 0, 1, 32'h14, 0);
        cyc(0, 1, 0, 32'h0, 0);
        chk("sat_stall_s", {62'd0, s_stall_cnt}, 64'd3);
        chk("sat_drop_s",  {62'd0, s_drop_cnt},  64'd3);
        chk("sat_stall",   {48'd0, stall_cnt},   64'd7);
        chk("sat_drop",    {48'd0, drop_cnt},    64'd4);

        // Reset together with flush while one entry is held
        cyc(1, 0, 0, 32'h0, 0);
        cyc(0, 0, 1, 32'h77, 0);
        cyc(1, 1, 1, 32'h99, 1);
        cyc(0, 0, 0, 32'h0, 0);
        chk("rstflush_drop",  {48'd0, drop_cnt},  64'd0);
        chk("rstflush_valid", {63'd0, out_valid}, 64'd0);
        chk("rstflush_data",  {32'd0, out_data},  64'd0);
        chk("rstflush_ready", {63'd0, in_ready},  64'd1);

        // Random traffic
        for (int i = 0; i < 3000; i++)
            cyc($urandom_range(0, 199) == 0, $urandom_range(0, 19) == 0,
                $urandom_range(0, 9) < 7, $urandom, $urandom_range(0, 9) < 6);
        cyc(0, 0, 0, 32'h0, 1);
        cyc(0, 0, 0, 32'h0, 1);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
